// File: rtl/game_turn_controller.sv
// rtl/game_turn_controller.sv - solitaire turn sequencer: setup gate, move screening/issue, timeout, stats, win detect
module game_turn_controller #(
   parameter int MOVE_CNT_W = 10,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  setup_ready,
   input  logic                  req_valid,
   input  logic [3:0]            req_source,
   input  logic [3:0]            req_source_offset,
   input  logic [3:0]            req_destination,
   output logic                  req_ack,
   output logic                  prompt_ready,
   output logic                  move_start,
   output logic [3:0]            move_source,
   output logic [3:0]            move_source_offset,
   output logic [3:0]            move_destination,
   input  logic                  move_done,
   input  logic                  successful,
   input  logic [44:0]           covered_cards,
   output logic                  result_valid,
   output logic                  result_ok,
   output logic [MOVE_CNT_W-1:0] move_count,
   output logic [MOVE_CNT_W-1:0] fail_count,
   output logic                  timeout_err,
   output logic                  game_won,
   output logic [2:0]            state
);
   localparam int WCNT_W = $clog2(TIMEOUT);
   localparam logic [WCNT_W-1:0]     WAIT_LAST = WCNT_W'(TIMEOUT - 1);
   localparam logic [MOVE_CNT_W-1:0] CNT_MAX   = '1;

   localparam logic [2:0] S_SETUP = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_WON   = 3'd5;

   logic [2:0]            state_next;
   logic [WCNT_W-1:0]     wait_cnt, wait_cnt_next;
   logic                  legal, wait_expired;
   logic                  req_ack_next, move_start_next, result_valid_next, result_ok_next;
   logic [3:0]            move_source_next, move_source_offset_next, move_destination_next;
   logic [MOVE_CNT_W-1:0] move_count_next, fail_count_next;
   logic                  timeout_err_next, game_won_next;

   // Source codes 9..15 are foundations or invalid, so a single bound covers both source rules.
   assign legal = (req_source <= 4'd8) && (req_destination <= 4'd12) &&
                  (req_destination != 4'd0) && (req_source != req_destination);
   assign wait_expired = (wait_cnt == WAIT_LAST);
   assign prompt_ready = (state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_SETUP;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_SETUP: if (setup_ready) state_next = S_IDLE;
         S_IDLE:  if (req_valid) state_next = legal ? S_ISSUE : S_CHECK;
         S_ISSUE: state_next = S_WAIT;
         S_WAIT:  if (move_done || wait_expired) state_next = S_CHECK;
         S_CHECK: state_next = (covered_cards == '0) ? S_WON : S_IDLE;
         S_WON:   state_next = S_WON;
         default: state_next = S_SETUP;
      endcase
   end

   always_comb begin
      req_ack_next            = 1'b0;
      move_start_next         = 1'b0;
      result_valid_next       = 1'b0;
      result_ok_next          = result_ok;
      move_source_next        = move_source;
      move_source_offset_next = move_source_offset;
      move_destination_next   = move_destination;
      move_count_next         = move_count;
      fail_count_next         = fail_count;
      timeout_err_next        = timeout_err;
      game_won_next           = game_won;
      wait_cnt_next           = wait_cnt;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               req_ack_next            = 1'b1;
               move_source_next        = req_source;
               move_source_offset_next = req_source_offset;
               move_destination_next   = req_destination;
               if (!legal) begin
                  result_valid_next = 1'b1;
                  result_ok_next    = 1'b0;
                  if (fail_count != CNT_MAX) fail_count_next = fail_count + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            move_start_next = 1'b1;
            wait_cnt_next   = '0;
         end
         S_WAIT: begin
            // A completion on the terminal-count cycle takes priority over the timeout.
            if (move_done) begin
               result_valid_next = 1'b1;
               result_ok_next    = successful;
               if (successful) begin
                  if (move_count != CNT_MAX) move_count_next = move_count + 1'b1;
               end else if (fail_count != CNT_MAX) begin
                  fail_count_next = fail_count + 1'b1;
               end
            end else if (wait_expired) begin
               result_valid_next = 1'b1;
               result_ok_next    = 1'b0;
               timeout_err_next  = 1'b1;
               if (fail_count != CNT_MAX) fail_count_next = fail_count + 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         S_CHECK: begin
            if (covered_cards == '0) game_won_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ack            <= 1'b0;
         move_start         <= 1'b0;
         result_valid       <= 1'b0;
         result_ok          <= 1'b0;
         move_source        <= '0;
         move_source_offset <= '0;
         move_destination   <= '0;
         move_count         <= '0;
         fail_count         <= '0;
         timeout_err        <= 1'b0;
         game_won           <= 1'b0;
         wait_cnt           <= '0;
      end else begin
         req_ack            <= req_ack_next;
         move_start         <= move_start_next;
         result_valid       <= result_valid_next;
         result_ok          <= result_ok_next;
         move_source        <= move_source_next;
         move_source_offset <= move_source_offset_next;
         move_destination   <= move_destination_next;
         move_count         <= move_count_next;
         fail_count         <= fail_count_next;
         timeout_err        <= timeout_err_next;
         game_won           <= game_won_next;
         wait_cnt           <= wait_cnt_next;
      end
   end
endmodule

// File: tb/tb_game_turn_controller.sv
// tb/tb_game_turn_controller.sv - randomized scoreboard bench for game_turn_controller
module tb_game_turn_controller;
   localparam int W       = 10;
   localparam int TIMEOUT = 64;
   localparam int CMAX    = (1 << W) - 1;

   logic clk = 1'b0, rst = 1'b1;
   logic setup_ready = 1'b0, req_valid = 1'b0;
   logic [3:0] req_source = '0, req_source_offset = '0, req_destination = '0;
   logic req_ack, prompt_ready, move_start;
   logic [3:0] move_source, move_source_offset, move_destination;
   logic move_done = 1'b0, successful = 1'b0;
   logic [44:0] covered_cards = 45'h1;
   logic result_valid, result_ok, timeout_err, game_won;
   logic [W-1:0] move_count, fail_count;
   logic [2:0] state;

   game_turn_controller #(.MOVE_CNT_W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .setup_ready(setup_ready), .req_valid(req_valid),
      .req_source(req_source), .req_source_offset(req_source_offset),
      .req_destination(req_destination), .req_ack(req_ack), .prompt_ready(prompt_ready),
      .move_start(move_start), .move_source(move_source),
      .move_source_offset(move_source_offset), .move_destination(move_destination),
      .move_done(move_done), .successful(successful), .covered_cards(covered_cards),
      .result_valid(result_valid), .result_ok(result_ok), .move_count(move_count),
      .fail_count(fail_count), .timeout_err(timeout_err), .game_won(game_won), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct { bit ok; int mc; int fc; bit terr; } exp_t;
   exp_t        exp_q[$];
   logic [11:0] mv_q[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, res_cnt = 0, res_cyc = 0;
   int m_mc = 0, m_fc = 0;
   bit m_terr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitors: pop expectations whenever the DUT presents a move or a result.
   always @(negedge clk) begin
      if (!rst && move_start) begin
         if (mv_q.size() == 0) chk("unexpected_move_start", 1, 0);
         else chk("move_fields", {move_source, move_source_offset, move_destination}, mv_q.pop_front());
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && result_valid) begin
         res_cyc = cyc;
         res_cnt++;
         if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("result_ok", result_ok, e.ok);
            chk("move_count", move_count, e.mc);
            chk("fail_count", fail_count, e.fc);
            chk("timeout_err", timeout_err, e.terr);
         end
      end
   end

   // d: cycles after move_start before move_done; d<0 never completes, d>=TIMEOUT arrives too late.
   task automatic do_req(input int src, input int off, input int dst, input int d, input bit succ);
      bit legal, tmo, ok;
      int ack_c, g, r0, lat;
      exp_t e;
      legal = (src <= 12) && (dst <= 12) && (src != dst) && (dst != 0) && !(src >= 9 && src <= 12);
      tmo   = legal && (d < 0 || d >= TIMEOUT);
      ok    = legal && !tmo && succ;
      if (ok) begin if (m_mc < CMAX) m_mc++; end
      else if (m_fc < CMAX) m_fc++;
      if (tmo) m_terr = 1;
      e.ok = ok; e.mc = m_mc; e.fc = m_fc; e.terr = m_terr;
      exp_q.push_back(e);
      if (legal) mv_q.push_back({src[3:0], off[3:0], dst[3:0]});
      r0 = res_cnt;
      @(negedge clk);
      req_valid = 1; req_source = src[3:0]; req_source_offset = off[3:0]; req_destination = dst[3:0];
      g = 0;
      while (!req_ack && g < 20) begin @(negedge clk); g++; end
      chk("ack_seen", req_ack, 1);
      ack_c = cyc;
      req_valid = 0;
      if (legal) begin
         g = 0;
         @(negedge clk);
         while (!move_start && g < 5) begin @(negedge clk); g++; end
         chk("start_latency", cyc - ack_c, 1);
         if (d >= 0 && d <= TIMEOUT) begin
            repeat (d) @(negedge clk);
            move_done = 1; successful = succ;
            @(negedge clk);
            move_done = 0; successful = 1'($urandom);
         end
      end
      g = 0;
      while (res_cnt == r0 && g < 200) begin @(negedge clk); g++; end
      chk("result_seen", res_cnt != r0, 1);
      lat = !legal ? 0 : tmo ? TIMEOUT + 1 : 2 + d;
      chk("result_latency", res_cyc - ack_c, lat);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_outs"}, {req_ack, prompt_ready, move_start, result_valid, result_ok, timeout_err, game_won}, 0);
      chk({tag, "_fields"}, {move_source, move_source_offset, move_destination}, 0);
      chk({tag, "_counts"}, {move_count, fail_count}, 0);
   endtask

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int src, dst, off, d, m;
      #1 chk_reset_vals("reset");
      repeat (3) @(negedge clk);
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("setup_hold_state", {state, prompt_ready}, {3'd0, 1'b0});
      end
      setup_ready = 1;
      @(negedge clk);
      chk("idle_after_setup", {state, prompt_ready}, {3'd1, 1'b1});
      setup_ready = 0;
      repeat (2) @(negedge clk);
      chk("setup_drop_ignored", state, 1);

      do_req(2, 0, 9, 2, 1);
      chk("first_move_count", move_count, 1);
      do_req(9, 0, 2, 0, 1);
      do_req(3, 0, 3, 0, 1);
      do_req(4, 0, 14, 0, 1);
      chk("illegal_fail_count", fail_count, 3);

      do_req(3, 0, 4, -1, 0);
      chk("timeout_sticky", timeout_err, 1);
      chk("back_to_idle", state, 1);
      do_req(3, 1, 4, TIMEOUT - 1, 1);
      do_req(5, 2, 6, TIMEOUT - 1, 0);

      for (int i = 0; i < 150; i++) begin
         covered_cards = {13'($urandom), $urandom} | 45'h1;
         m   = $urandom_range(0, 9);
         src = (m == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
         dst = (m == 1) ? $urandom_range(0, 15) : $urandom_range(1, 12);
         off = $urandom_range(0, 15);
         m   = $urandom_range(0, 19);
         d   = (m == 0) ? -1 : (m == 1) ? TIMEOUT - 1 : (m == 2) ? TIMEOUT : $urandom_range(0, 8);
         do_req(src, off, dst, d, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 1025; i++) do_req(1, 0, 2 + (i % 7), 0, 1);
      chk("move_count_saturated", move_count, CMAX);

      covered_cards = '0;
      do_req(2, 0, 3, 1, 1);
      chk("won_state", {state, game_won, prompt_ready}, {3'd5, 1'b1, 1'b0});
      req_valid = 1; req_source = 4'd2; req_destination = 4'd4;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("won_no_ack", {req_ack, state}, {1'b0, 3'd5});
      end
      req_valid = 0;
      #2 rst = 1;
      #1 chk_reset_vals("won_reset");
      m_mc = 0; m_fc = 0; m_terr = 0;
      covered_cards = 45'h3;

      @(negedge clk);
      rst = 0; setup_ready = 1;
      @(negedge clk);
      chk("idle_again", state, 1);
      mv_q.push_back({4'd4, 4'd1, 4'd5});
      req_valid = 1; req_source = 4'd4; req_source_offset = 4'd1; req_destination = 4'd5;
      @(negedge clk);
      chk("mid_ack", req_ack, 1);
      req_valid = 0;
      @(negedge clk);
      chk("mid_move_start", move_start, 1);
      #2 rst = 1;
      #1 chk("reset_drops_start", {move_start, state}, {1'b0, 3'd0});
      @(negedge clk);
      rst = 0;
      chk("queues_drained", exp_q.size() + mv_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
